// File: rtl/hamming_enc_seq_pkg.sv
// Shared constants, state encoding and helpers for the sequential Hamming encoder.
package hamming_pkg;

    localparam int unsigned MAX_K = 26;
    localparam int unsigned MAX_R = 5;
    localparam int unsigned MAX_N = MAX_K + MAX_R;
    localparam int unsigned LEN_W = 8;
    localparam int unsigned CNT_W = MAX_R + 1;
    localparam int unsigned JW    = $clog2(MAX_K);
    localparam int unsigned IDX_W = $clog2(MAX_N);

    typedef enum logic [2:0] {
        IDLE,
        CALC_R,
        SCATTER,
        PARITY,
        DONE
    } state_e;

    function automatic logic is_pow2(input logic [CNT_W-1:0] v);
        return (v & (v - CNT_W'(1))) == '0;
    endfunction

endpackage

// File: rtl/hamming_enc_seq_if.sv
// Source-side word handshake and sink-side codeword handshake of the encoder.
interface hamming_enc_seq_if;
    import hamming_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [MAX_K-1:0] data_in;
    logic [LEN_W-1:0] len_in;
    logic             out_valid;
    logic             out_ready;
    logic [MAX_N-1:0] code_out;
    logic [LEN_W-1:0] len_out;
    logic             busy;
    logic             err;

    modport master (
        output in_valid, data_in, len_in, out_ready,
        input  in_ready, out_valid, code_out, len_out, busy, err
    );

    modport slave (
        input  in_valid, data_in, len_in, out_ready,
        output in_ready, out_valid, code_out, len_out, busy, err
    );

endinterface

// File: rtl/hamming_enc_seq.sv
// Multi-cycle Hamming encoder: derives r, scatters data one position per cycle
// while accumulating the syndrome, then drops the syndrome into the parity slots.
module hamming_enc_seq
    import hamming_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    hamming_enc_seq_if.slave  bus
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] k_q, k_d;
    logic [MAX_K-1:0] data_q, data_d;
    logic [CNT_W-1:0] r_q, r_d;
    logic [CNT_W-1:0] pos_q, pos_d;
    logic [JW-1:0]    j_q, j_d;
    logic [CNT_W-1:0] s_q, s_d;
    logic [MAX_N-1:0] code_q, code_d;
    logic [LEN_W-1:0] n_q, n_d;
    logic             err_d;
    logic             in_ready_q, out_valid_q, busy_q, err_q;
    logic [MAX_K-1:0] mask_c;
    logic             cur_bit;

    // Data bits at or above len_in are discarded on capture.
    always_comb begin
        mask_c = '0;
        for (int unsigned b = 0; b < MAX_K; b++) begin
            mask_c[b] = (LEN_W'(b) < bus.len_in);
        end
    end

    assign cur_bit = (j_q < JW'(MAX_K)) ? data_q[j_q] : 1'b0;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        data_d  = data_q;
        r_d     = r_q;
        pos_d   = pos_q;
        j_d     = j_q;
        s_d     = s_q;
        code_d  = code_q;
        n_d     = n_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    if ((bus.len_in == '0) || (bus.len_in > LEN_W'(MAX_K))) begin
                        err_d = 1'b1;
                    end else begin
                        k_d     = bus.len_in;
                        data_d  = bus.data_in & mask_c;
                        r_d     = CNT_W'(2);
                        pos_d   = CNT_W'(1);
                        j_d     = '0;
                        s_d     = '0;
                        code_d  = '0;
                        state_d = CALC_R;
                    end
                end
            end
            CALC_R: begin
                if ((32'(1) << r_q) >= (32'(k_q) + 32'(r_q) + 32'd1)) begin
                    n_d     = k_q + LEN_W'(r_q);
                    state_d = SCATTER;
                end else begin
                    r_d = r_q + CNT_W'(1);
                end
            end
            SCATTER: begin
                if (!is_pow2(pos_q)) begin
                    for (int unsigned b = 0; b < MAX_N; b++) begin
                        if (pos_q == CNT_W'(b + 1)) code_d[b] = cur_bit;
                    end
                    j_d = j_q + JW'(1);
                    if (cur_bit) s_d = s_q ^ pos_q;
                end
                pos_d = pos_q + CNT_W'(1);
                if (LEN_W'(pos_q) == n_q) state_d = PARITY;
            end
            PARITY: begin
                // Syndrome bit i is exactly the even-parity bit for position 2^i.
                for (int unsigned i = 0; i < MAX_R; i++) begin
                    if (i < 32'(r_q)) code_d[IDX_W'((1 << i) - 1)] = s_q[i];
                end
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            data_q      <= '0;
            r_q         <= '0;
            pos_q       <= '0;
            j_q         <= '0;
            s_q         <= '0;
            code_q      <= '0;
            n_q         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            data_q      <= data_d;
            r_q         <= r_d;
            pos_q       <= pos_d;
            j_q         <= j_d;
            s_q         <= s_d;
            code_q      <= code_d;
            n_q         <= n_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
            err_q       <= err_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
    assign bus.code_out  = code_q;
    assign bus.len_out   = n_q;

endmodule

// File: tb/tb_hamming_enc_seq.sv
// Directed and randomized self-checking bench for hamming_enc_seq.
module tb_hamming_enc_seq;
    import hamming_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    hamming_enc_seq_if bus();

    hamming_enc_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic int ref_r(input int k);
        int r = 1;
        while ((1 << r) < k + r + 1) r++;
        return r;
    endfunction

    // Textbook construction: place data, then compute each parity group directly.
    function automatic logic [MAX_N-1:0] ref_code(input int k, input logic [MAX_K-1:0] d);
        int r = ref_r(k);
        int n = k + r;
        int j = 0;
        logic [MAX_N-1:0] c = '0;
        logic p;
        for (int pos = 1; pos <= n; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos-1] = d[j];
                j++;
            end
        end
        for (int i = 0; i < r; i++) begin
            p = 1'b0;
            for (int pos = 1; pos <= n; pos++) begin
                if ((pos & (1 << i)) != 0) p = p ^ c[pos-1];
            end
            c[(1 << i) - 1] = p;
        end
        return c;
    endfunction

    task automatic send(input logic [7:0] len, input logic [MAX_K-1:0] data,
                        input bit rand_rdy, output int lat);
        int w = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.len_in   = len;
        bus.data_in  = data;
        while (!bus.in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic release_word();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.code_out !== '0) begin errors++; $display("FAIL rst_code got %h want 0", bus.code_out); end
        checks++; if (bus.len_out !== '0) begin errors++; $display("FAIL rst_len got %0d want 0", bus.len_out); end
        checks++; if ({bus.busy, bus.err} !== 2'b00) begin errors++; $display("FAIL rst_busy_err got %b want 00", {bus.busy, bus.err}); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_k4();
        int lat;
        bus.out_ready = 1'b1;
        send(8'd4, 26'b1011, 1'b0, lat);
        checks++; if (lat !== 10) begin errors++; $display("FAIL k4_latency got %0d want 10", lat); end
        checks++; if (bus.code_out !== 31'h55) begin errors++; $display("FAIL k4_code got %h want 55", bus.code_out); end
        checks++; if (bus.len_out !== 8'd7) begin errors++; $display("FAIL k4_len got %0d want 7", bus.len_out); end
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++; if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b010) begin
            errors++; $display("FAIL k4_return got v/r/b %b want 010", {bus.out_valid, bus.in_ready, bus.busy}); end
    endtask

    task automatic test_k1_k26();
        int lat;
        int bad;
        logic p;
        send(8'd1, 26'h1, 1'b0, lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL k1_latency got %0d want 5", lat); end
        checks++; if (bus.code_out !== 31'h7) begin errors++; $display("FAIL k1_code got %h want 7", bus.code_out); end
        checks++; if (bus.len_out !== 8'd3) begin errors++; $display("FAIL k1_len got %0d want 3", bus.len_out); end
        release_word();
        send(8'd26, 26'h3FFFFFF, 1'b0, lat);
        checks++; if (lat !== 36) begin errors++; $display("FAIL k26_latency got %0d want 36", lat); end
        checks++; if (bus.code_out !== 31'h7FFFFFFF) begin errors++; $display("FAIL k26_code got %h want 7fffffff", bus.code_out); end
        checks++; if (bus.len_out !== 8'd31) begin errors++; $display("FAIL k26_len got %0d want 31", bus.len_out); end
        bad = 0;
        for (int i = 0; i < MAX_R; i++) begin
            p = 1'b0;
            for (int pos = 1; pos <= 31; pos++) if ((pos & (1 << i)) != 0) p = p ^ bus.code_out[pos-1];
            if (p) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL k26_groups odd groups %0d want 0", bad); end
        release_word();
    endtask

    task automatic test_illegal();
        logic [7:0] bad_len [2];
        bad_len[0] = 8'd0;
        bad_len[1] = 8'd27;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.len_in   = bad_len[t];
            bus.data_in  = '1;
            @(posedge clk);
            @(negedge clk);
            bus.in_valid = 1'b0;
            checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL illegal_err len %0d got %b want 1", bad_len[t], bus.err); end
            checks++; if ({bus.in_ready, bus.busy} !== 2'b10) begin
                errors++; $display("FAIL illegal_state len %0d got r/b %b want 10", bad_len[t], {bus.in_ready, bus.busy}); end
            @(negedge clk);
            checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL illegal_pulse len %0d got %b want 0", bad_len[t], bus.err); end
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                checks++; if ({bus.out_valid, bus.busy} !== 2'b00) begin
                    errors++; $display("FAIL illegal_quiet len %0d got v/b %b want 00", bad_len[t], {bus.out_valid, bus.busy}); end
            end
        end
    endtask

    task automatic test_stall();
        int lat;
        send(8'd8, 26'hA5, 1'b0, lat);
        checks++; if (lat !== 16) begin errors++; $display("FAIL stall_latency got %0d want 16", lat); end
        for (int c = 0; c < 20; c++) begin
            bus.in_valid = 1'b1;
            bus.len_in   = 8'd3;
            bus.data_in  = 26'h7;
            @(posedge clk);
            @(negedge clk);
            checks++; if ({bus.out_valid, bus.in_ready} !== 2'b10 || bus.code_out !== 31'hA27 || bus.len_out !== 8'd12) begin
                errors++; $display("FAIL stall_hold cyc %0d got v/r %b code %h len %0d want 10 a27 12",
                                   c, {bus.out_valid, bus.in_ready}, bus.code_out, bus.len_out); end
        end
        bus.in_valid = 1'b0;
        release_word();
        checks++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            errors++; $display("FAIL stall_release got v/r %b want 01", {bus.out_valid, bus.in_ready}); end
        @(negedge clk);
        checks++; if ({bus.out_valid, bus.busy} !== 2'b00) begin
            errors++; $display("FAIL stall_single got v/b %b want 00", {bus.out_valid, bus.busy}); end
    endtask

    task automatic test_reset_mid();
        int lat;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.len_in   = 8'd11;
        bus.data_in  = 26'h123;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if ({bus.in_ready, bus.out_valid, bus.busy, bus.err} !== 4'b0000) begin
            errors++; $display("FAIL midrst_flags got r/v/b/e %b want 0000", {bus.in_ready, bus.out_valid, bus.busy, bus.err}); end
        checks++; if (bus.code_out !== '0 || bus.len_out !== '0) begin
            errors++; $display("FAIL midrst_data got code %h len %0d want 0 0", bus.code_out, bus.len_out); end
        @(negedge clk);
        reset = 1'b0;
        send(8'd11, 26'h7FF, 1'b0, lat);
        checks++; if (lat !== 19) begin errors++; $display("FAIL midrst_latency got %0d want 19", lat); end
        checks++; if (bus.code_out !== 31'h7FFF) begin errors++; $display("FAIL midrst_code got %h want 7fff", bus.code_out); end
        checks++; if (bus.len_out !== 8'd15) begin errors++; $display("FAIL midrst_len got %0d want 15", bus.len_out); end
        release_word();
    endtask

    task automatic test_random();
        int k, n, lat, stall;
        logic [MAX_K-1:0] d;
        logic [MAX_N-1:0] exp_code;
        for (int it = 0; it < 40; it++) begin
            k        = $urandom_range(1, MAX_K);
            d        = MAX_K'($urandom);
            n        = k + ref_r(k);
            exp_code = ref_code(k, d);
            send(8'(k), d, 1'b1, lat);
            bus.out_ready = 1'b0;
            checks++; if (lat !== ref_r(k) - 1 + n + 1) begin
                errors++; $display("FAIL rand_latency k %0d got %0d want %0d", k, lat, ref_r(k) + n); end
            checks++; if (bus.code_out !== exp_code || bus.len_out !== 8'(n)) begin
                errors++; $display("FAIL rand_code k %0d data %h got %h len %0d want %h len %0d",
                                   k, d, bus.code_out, bus.len_out, exp_code, n); end
            checks++; if ((bus.code_out >> n) !== '0) begin
                errors++; $display("FAIL rand_upper k %0d got %h want upper bits 0", k, bus.code_out); end
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                @(posedge clk);
                @(negedge clk);
                checks++; if (bus.out_valid !== 1'b1 || bus.code_out !== exp_code) begin
                    errors++; $display("FAIL rand_hold k %0d got v %b code %h want 1 %h", k, bus.out_valid, bus.code_out, exp_code); end
            end
            release_word();
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rand_drop k %0d got %b want 0", k, bus.out_valid); end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.len_in    = '0;
        bus.data_in   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_k4();
        test_k1_k26();
        test_illegal();
        test_stall();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hamming_enc_seq.md
# hamming_enc_seq

Multi-cycle sequencer for the Hamming encoder datapath. Accepts a variable-length data word over a valid/ready handshake and derives the parity-bit count r. It walks codeword positions 1..n one per cycle, scattering data bits into non-power-of-two positions and accumulating the parity syndrome. It then inserts the even-parity bits and presents the codeword plus its length downstream. It sits between the data source and the channel/storage interface that consumes encoded words.

## Interface
- MAX_K, 26, maximum data bits per word.
- MAX_R, 5, maximum parity bits; requires 2^MAX_R >= MAX_K+MAX_R+1.
- MAX_N, 31, maximum codeword bits (MAX_K+MAX_R).
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- in_valid  input  1  data_in/len_in valid.
- in_ready  output  1  block can accept a word.
- data_in  input  MAX_K  data bits, d1 = data_in[0]; bits at or above len_in ignored.
- len_in  input  8  data length k; legal range 1..MAX_K.
- out_valid  output  1  code_out/len_out valid.
- out_ready  input  1  downstream accepts codeword.
- code_out  output  MAX_N  codeword; position p at code_out[p-1]; bits at or above n are 0.
- len_out  output  8  codeword length n = k+r.
- busy  output  1  high in any state except IDLE.
- err  output  1  one-cycle pulse on acceptance of an illegal len_in.

## Operation
- States: IDLE, CALC_R, SCATTER, PARITY, DONE.
- IDLE: in_ready=1. On in_valid, register k and the data word masked to k bits.
  - If k=0 or k>MAX_K: pulse err, stay IDLE.
  - Otherwise: r<=2, pos<=1, data index j<=0, syndrome S<=0, codeword register <=0; go to CALC_R.
- CALC_R: each cycle tests the current r.
  - If 2^r >= k+r+1: latch n=k+r, go to SCATTER.
  - Else r<=r+1.
- SCATTER: one position per cycle.
  - If pos is a power of two: leave bit pos-1 at 0.
  - Else: bit pos-1 <= d[j], j<=j+1, and if d[j]=1 then S<=S^pos.
  - pos<=pos+1; after pos=n, go to PARITY.
- PARITY: single cycle. For i in 0..r-1, bit (2^i)-1 <= S[i]. Go to DONE.
- DONE: out_valid=1; code_out and len_out stable. On out_ready, go to IDLE.
- Arithmetic: pos, S and r are MAX_R+1 bits wide. The power-of-two test is (pos & (pos-1)) == 0. No wrap is possible for legal k.
- Resulting code has even parity on every parity group.

## Timing
- Reset values: in_ready=0 while reset is asserted, then 1 (IDLE). out_valid=0, code_out=0, len_out=0, busy=0, err=0.
- Accept at edge E0 → out_valid rises after (r-1)+n+1 cycles.
  - k=1: 5 cycles.
  - k=4: 10 cycles.
  - k=26: 36 cycles.
- in_ready is low from the cycle after acceptance until the cycle after the output handshake; no back-to-back overlap.
- out_valid and outputs are held indefinitely while out_ready=0.
- out_ready is ignored outside DONE.
- err is asserted the cycle after the illegal word is accepted; in_ready stays 1.
- Reset mid-operation (any state) immediately returns to IDLE. The in-flight word is dropped and outputs return to reset values.
- in_valid during a busy state is ignored; the source must hold it until in_ready.

## Structure
- Package hamming_pkg holds:
  - the state enum (IDLE, CALC_R, SCATTER, PARITY, DONE);
  - the MAX_K/MAX_R/MAX_N defaults;
  - the is_pow2 function;
  - the LEN_W=8 constant.
- Single module. No sub-module is needed; the FSM, counters and codeword register live together.

## Test plan
- k=4, data_in=4'b1011, out_ready=1 → after 10 cycles out_valid=1, code_out=0x55, len_out=7; in_ready returns the following cycle.
- k=1, data_in=1 → code_out=3'b111, len_out=3, latency 5. Then k=26 with all ones → len_out=31, latency 36, every parity group even.
- len_in=0, then len_in=27 → err pulses one cycle each; state stays IDLE; out_valid never rises.
- Hold out_ready=0 for 20 cycles in DONE → code_out stable, new in_valid is ignored. Release → single handshake, then IDLE.
- Assert reset during SCATTER of a k=11 word → all outputs read reset values immediately. The next k=11 word (data 0x7FF) yields len_out=15 and a correct codeword with no residue from the aborted word.
- Random k 1..26 and random data, with random out_ready stalls, checked against a reference model → every codeword matches, and the bits of code_out at and above n are 0.
